// File: rtl/dot_issue_pkg.sv
// Shared types and constants for the dot-product row issuer and the vecvec wrappers.
// Holds the FSM state encoding and the row-slice offset helper.
package dot_issue_pkg;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_BIN_POS     = 16;
  localparam int DEF_VECTOR_SIZE = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Bit offset of element/row `idx` in a packed array of `count`-element, `width`-bit groups.
  function automatic int unsigned row_lsb(input int unsigned idx, input int unsigned count,
                                          input int unsigned width);
    return idx * count * width;
  endfunction

endpackage

// File: rtl/dot_watchdog.sv
// Clear/enable cycle counter that saturates and flags expiry once it reaches TIMEOUT.
// Expiry is registered-count based: asserted the cycle the count equals or exceeds TIMEOUT.
module dot_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q >= CW'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dot_row_issuer.sv
// Issues each captured matrix row to one vecvec engine via rst/ready/complete and gathers results.
// Per row: 2 LOAD cycles minimum plus engine run time; a watchdog aborts a stuck row with error.
module dot_row_issuer
  import dot_issue_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int BIN_POS     = DEF_BIN_POS,
  parameter int VECTOR_SIZE = DEF_VECTOR_SIZE,
  parameter int ROWS        = 3,
  parameter int TIMEOUT     = 1024
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [ROWS*VECTOR_SIZE*WIDTH-1:0] mat,
  input  logic [VECTOR_SIZE*WIDTH-1:0]      vec,
  output logic                              busy,
  output logic                              done,
  output logic                              error,
  output logic [ROWS*WIDTH-1:0]             result,
  output logic                              eng_rst,
  input  logic                              eng_ready,
  input  logic                              eng_complete,
  output logic [VECTOR_SIZE*WIDTH-1:0]      eng_vec_a,
  output logic [VECTOR_SIZE*WIDTH-1:0]      eng_vec_b,
  input  logic [WIDTH-1:0]                  eng_dot
);

  localparam int ROW_W = VECTOR_SIZE * WIDTH;
  localparam int MAT_W = ROWS * ROW_W;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_LOAD = LOAD;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  if (BIN_POS >= WIDTH) begin : g_bad_bin_pos
    $error("BIN_POS must be below WIDTH");
  end

  logic [1:0]           state_q, state_d;
  logic [RW-1:0]        row_q, row_d;
  logic                 first_q, first_d;
  logic [MAT_W-1:0]     mat_q, mat_d;
  logic [ROW_W-1:0]     vec_q, vec_d;
  logic [ROWS*WIDTH-1:0] res_q, res_d;
  logic                 err_q, err_d;
  logic                 wd_clr, wd_en, wd_exp;

  dot_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .expired(wd_exp)
  );

  assign wd_en = (state_q == ST_LOAD) || (state_q == ST_RUN);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    first_d = first_q;
    mat_d   = mat_q;
    vec_d   = vec_q;
    res_d   = res_q;
    err_d   = err_q;
    wd_clr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mat_d   = mat;
          vec_d   = vec;
          res_d   = '0;
          err_d   = 1'b0;
          row_d   = '0;
          first_d = 1'b1;
          wd_clr  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // The first LOAD cycle ignores ready so a stale ready from the last row cannot skip reset.
        first_d = 1'b0;
        if (wd_exp) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (!first_q && eng_ready) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (wd_exp) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (eng_complete) begin
          res_d[row_lsb(32'(row_q), 1, WIDTH) +: WIDTH] = eng_dot;
          if (row_q == RW'(ROWS - 1)) begin
            state_d = ST_DONE;
          end else begin
            row_d   = row_q + 1'b1;
            first_d = 1'b1;
            wd_clr  = 1'b1;
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      first_q <= 1'b0;
      mat_q   <= '0;
      vec_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      first_q <= first_d;
      mat_q   <= mat_d;
      vec_q   <= vec_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // Operands only move when row_q or the capture registers change, both of which happen on LOAD entry.
  assign eng_vec_a = mat_q[row_lsb(32'(row_q), VECTOR_SIZE, WIDTH) +: ROW_W];
  assign eng_vec_b = vec_q;
  assign eng_rst   = (state_q != ST_RUN);
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign error     = err_q;
  assign result    = res_q;

endmodule

// File: tb/tb_dot_row_issuer.sv
// Directed bench for dot_row_issuer with a stub Q16 dot engine (K=4 run cycles, TIMEOUT=16).
module tb_dot_row_issuer;

  localparam int W  = 32;
  localparam int VS = 3;
  localparam int R  = 3;
  localparam int TO = 16;
  localparam int K  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [R*VS*W-1:0] mat = '0;
  logic [VS*W-1:0]   vec = '0;
  logic              busy, done, error, eng_rst, eng_ready, eng_complete;
  logic [R*W-1:0]    result;
  logic [VS*W-1:0]   eng_vec_a, eng_vec_b;
  logic [W-1:0]      eng_dot;

  logic              hold_ready = 1'b0;
  logic              force_cmpl = 1'b0;
  logic              stall_en = 1'b0;
  logic [2:0]        run_cnt = '0;
  logic              ready_q = 1'b0;

  logic [R*VS*W-1:0] mat_a, mat_b;
  logic [VS*W-1:0]   vec_a, vec_c;
  logic [R*W-1:0]    exp_a, exp_c, exp_to;

  int checks = 0;
  int failures = 0;

  dot_row_issuer #(
    .WIDTH(W), .BIN_POS(16), .VECTOR_SIZE(VS), .ROWS(R), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mat(mat), .vec(vec),
    .busy(busy), .done(done), .error(error), .result(result),
    .eng_rst(eng_rst), .eng_ready(eng_ready), .eng_complete(eng_complete),
    .eng_vec_a(eng_vec_a), .eng_vec_b(eng_vec_b), .eng_dot(eng_dot)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] dotq(input logic [VS*W-1:0] a, input logic [VS*W-1:0] b);
    longint s;
    s = 0;
    for (int i = 0; i < VS; i++)
      s += (longint'($signed(a[i*W +: W])) * longint'($signed(b[i*W +: W]))) >>> 16;
    return s[W-1:0];
  endfunction

  // Stub engine: ready one cycle after rst is seen, complete in the K-th cycle with rst low.
  always @(posedge clk) begin
    run_cnt <= eng_rst ? 3'd0 : run_cnt + 3'd1;
    ready_q <= eng_rst;
  end

  logic stall;
  assign stall        = stall_en && (eng_vec_a == mat_a[VS*W +: VS*W]);
  assign eng_ready    = hold_ready | ready_q;
  assign eng_complete = (!eng_rst && run_cnt == 3'(K - 1) && !stall) || (force_cmpl && eng_rst);
  assign eng_dot      = (force_cmpl && eng_rst) ? 32'hDEADBEEF : dotq(eng_vec_a, eng_vec_b);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start (cycle 1) and steps until done; cyc is the cycle index in which done is high.
  task automatic run_job(input int inj_cyc, output int cyc, output int min_ld, output int max_ld,
                         output int bad_chg, output logic [VS*W-1:0] a0, output logic [VS*W-1:0] b0,
                         output logic [2:0] ctl0);
    int ld;
    logic [VS*W-1:0] pa, pb;
    ld = 0; min_ld = 1000; max_ld = 0; bad_chg = 0;
    start = 1'b1; cyc = 1;
    tick();
    start = 1'b0; cyc = 2;
    a0 = eng_vec_a; b0 = eng_vec_b; ctl0 = {eng_rst, busy, done};
    pa = eng_vec_a; pb = eng_vec_b;
    while (!done && cyc < 200) begin
      if (cyc == inj_cyc) begin
        start = 1'b1;
        mat = mat_b;
      end else begin
        start = 1'b0;
      end
      if (busy && eng_rst) begin
        ld++;
      end else if (ld > 0) begin
        if (ld < min_ld) min_ld = ld;
        if (ld > max_ld) max_ld = ld;
        ld = 0;
      end
      if ((eng_vec_a !== pa || eng_vec_b !== pb) && !eng_rst) bad_chg++;
      pa = eng_vec_a; pb = eng_vec_b;
      tick();
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++;
    if ({eng_rst, busy, done, error} !== 4'b1000) begin
      failures++; $display("FAIL reset_ctl got=%b want=1000", {eng_rst, busy, done, error});
    end
    checks++;
    if (result !== '0) begin failures++; $display("FAIL reset_result got=%h want=0", result); end
    checks++;
    if ({eng_vec_a, eng_vec_b} !== '0) begin
      failures++; $display("FAIL reset_operands got=%h/%h want=0", eng_vec_a, eng_vec_b);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int cyc, mn, mx, bad;
    logic [VS*W-1:0] a0, b0;
    logic [2:0] c0;
    mat = mat_a; vec = vec_a;
    run_job(0, cyc, mn, mx, bad, a0, b0, c0);
    checks++;
    if (a0 !== mat_a[0 +: VS*W] || b0 !== vec_a) begin
      failures++; $display("FAIL basic_first_operands got=%h/%h want=%h/%h", a0, b0, mat_a[0 +: VS*W], vec_a);
    end
    checks++;
    if (c0 !== 3'b110) begin failures++; $display("FAIL basic_first_load_ctl got=%b want=110", c0); end
    checks++;
    if (cyc !== 20) begin failures++; $display("FAIL basic_done_cycle got=%0d want=20", cyc); end
    checks++;
    if (result !== exp_a) begin failures++; $display("FAIL basic_result got=%h want=%h", result, exp_a); end
    checks++;
    if ({error, busy} !== 2'b00) begin failures++; $display("FAIL basic_err_busy got=%b want=00", {error, busy}); end
    checks++;
    if (mn !== 2 || mx !== 2) begin failures++; $display("FAIL basic_load_len got=%0d..%0d want=2..2", mn, mx); end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL basic_operand_stability got=%0d want=0", bad); end
    tick();
    checks++;
    if ({done, busy, eng_rst} !== 3'b001) begin
      failures++; $display("FAIL basic_done_pulse got=%b want=001", {done, busy, eng_rst});
    end
  endtask

  task automatic test_hold_ready();
    int cyc, mn, mx, bad;
    logic [VS*W-1:0] a0, b0;
    logic [2:0] c0;
    hold_ready = 1'b1;
    run_job(0, cyc, mn, mx, bad, a0, b0, c0);
    hold_ready = 1'b0;
    checks++;
    if (mn !== 2 || mx !== 2) begin failures++; $display("FAIL hold_ready_load_len got=%0d..%0d want=2..2", mn, mx); end
    checks++;
    if (cyc !== 20) begin failures++; $display("FAIL hold_ready_done_cycle got=%0d want=20", cyc); end
    checks++;
    if (result !== exp_a) begin failures++; $display("FAIL hold_ready_result got=%h want=%h", result, exp_a); end
    tick();
  endtask

  task automatic test_early_complete();
    int cyc, mn, mx, bad;
    logic [VS*W-1:0] a0, b0;
    logic [2:0] c0;
    force_cmpl = 1'b1;
    run_job(0, cyc, mn, mx, bad, a0, b0, c0);
    force_cmpl = 1'b0;
    checks++;
    if (result !== exp_a) begin failures++; $display("FAIL early_cmpl_result got=%h want=%h", result, exp_a); end
    checks++;
    if (cyc !== 20) begin failures++; $display("FAIL early_cmpl_done_cycle got=%0d want=20", cyc); end
    tick();
  endtask

  task automatic test_start_while_busy();
    int cyc, mn, mx, bad;
    logic [VS*W-1:0] a0, b0;
    logic [2:0] c0;
    run_job(7, cyc, mn, mx, bad, a0, b0, c0);
    checks++;
    if (result !== exp_a) begin failures++; $display("FAIL busy_start_result got=%h want=%h", result, exp_a); end
    checks++;
    if (cyc !== 20) begin failures++; $display("FAIL busy_start_done_cycle got=%0d want=20", cyc); end
    mat = mat_a;
    tick();
  endtask

  task automatic test_back_to_back();
    int cyc, mn, mx, bad;
    logic [VS*W-1:0] a0, b0;
    logic [2:0] c0;
    run_job(0, cyc, mn, mx, bad, a0, b0, c0);
    start = 1'b1;  // driven during the DONE cycle
    tick();
    start = 1'b0;
    checks++;
    if ({busy, eng_rst} !== 2'b01) begin failures++; $display("FAIL done_cycle_start got=%b want=01", {busy, eng_rst}); end
    vec = vec_c;
    run_job(0, cyc, mn, mx, bad, a0, b0, c0);
    checks++;
    if (result !== exp_c) begin failures++; $display("FAIL b2b_result got=%h want=%h", result, exp_c); end
    checks++;
    if (cyc !== 20) begin failures++; $display("FAIL b2b_done_cycle got=%0d want=20", cyc); end
    vec = vec_a;
    tick();
  endtask

  task automatic test_timeout();
    int cyc, mn, mx, bad;
    logic [VS*W-1:0] a0, b0;
    logic [2:0] c0;
    stall_en = 1'b1;
    run_job(0, cyc, mn, mx, bad, a0, b0, c0);
    stall_en = 1'b0;
    // Row 0 spans edges 1..6; row 1 count reaches 16 after 16 more edges, DONE one edge later.
    checks++;
    if (cyc !== 25) begin failures++; $display("FAIL timeout_done_cycle got=%0d want=25", cyc); end
    checks++;
    if (error !== 1'b1) begin failures++; $display("FAIL timeout_error got=%b want=1", error); end
    checks++;
    if (result !== exp_to) begin failures++; $display("FAIL timeout_result got=%h want=%h", result, exp_to); end
    tick();
    checks++;
    if ({error, busy} !== 2'b10) begin failures++; $display("FAIL timeout_sticky got=%b want=10", {error, busy}); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({error, busy} !== 2'b01) begin failures++; $display("FAIL timeout_clear got=%b want=01", {error, busy}); end
    repeat (40) tick();
    checks++;
    if (result !== exp_a || error !== 1'b0) begin
      failures++; $display("FAIL timeout_recover got=%h/%b want=%h/0", result, error, exp_a);
    end
  endtask

  task automatic test_rst_in_run();
    int cyc, mn, mx, bad;
    logic [VS*W-1:0] a0, b0;
    logic [2:0] c0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    checks++;
    if ({eng_rst, busy} !== 2'b01 || result[W-1:0] !== 32'h70000) begin
      failures++; $display("FAIL rst_pre_state got=%b/%h want=01/00070000", {eng_rst, busy}, result[W-1:0]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({eng_rst, busy, done, error} !== 4'b1000) begin
      failures++; $display("FAIL rst_run_ctl got=%b want=1000", {eng_rst, busy, done, error});
    end
    checks++;
    if (result !== '0 || eng_vec_a !== '0) begin
      failures++; $display("FAIL rst_run_clear got=%h/%h want=0/0", result, eng_vec_a);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_run_idle got=%b want=0", busy); end
    vec = vec_c;
    run_job(0, cyc, mn, mx, bad, a0, b0, c0);
    checks++;
    if (result !== exp_c || cyc !== 20) begin
      failures++; $display("FAIL rst_new_job got=%h@%0d want=%h@20", result, cyc, exp_c);
    end
    tick();
  endtask

  initial begin
    for (int r = 0; r < R; r++)
      for (int i = 0; i < VS; i++) begin
        mat_a[(r*VS + i)*W +: W] = 32'((r*VS + i + 1) << 16);
        mat_b[(r*VS + i)*W +: W] = 32'h50000;
      end
    vec_a  = {32'h20000, 32'h0, 32'h10000};
    vec_c  = {32'h10000, 32'h10000, 32'h10000};
    exp_a  = {32'h190000, 32'h100000, 32'h70000};
    exp_c  = {32'h180000, 32'hF0000, 32'h60000};
    exp_to = {32'h0, 32'h0, 32'h70000};
    mat = mat_a;
    vec = vec_a;

    test_reset();
    test_basic();
    test_hold_ready();
    test_early_complete();
    test_start_while_busy();
    test_back_to_back();
    test_timeout();
    test_rst_in_run();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
